// File: rtl/fp24_pkg.sv
// Shared format constants, operand classification and rounding helpers for
// the custom 24-bit floating-point format (1 sign, 7 exponent, 16 fraction).
package fp24_pkg;

  localparam int EXP_W   = 7;
  localparam int FRAC_W  = 16;
  localparam int BIAS    = 63;
  localparam int EXP_MAX = 127;

  // Significand with hidden bit, then extended with guard/round/sticky.
  localparam int SIG_W = FRAC_W + 1;
  localparam int EXT_W = SIG_W + 3;
  localparam int LZC_W = 5;

  localparam logic [2:0] RND_NE = 3'b000;
  localparam logic [2:0] RND_RZ = 3'b001;
  localparam logic [2:0] RND_UP = 3'b010;
  localparam logic [2:0] RND_DN = 3'b011;

  localparam logic [23:0] QNAN    = 24'h7F8000;
  localparam logic [23:0] MAX_FIN = 24'h7EFFFF;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp24_t;

  typedef struct packed {
    logic             zero;
    logic             inf;
    logic             nan;
    logic [SIG_W-1:0] sig;
  } fp24_class_t;

  // Exponent 0 is zero regardless of fraction, so denormals flush here.
  function automatic fp24_class_t classify(input fp24_t x);
    fp24_class_t c;
    c.zero = (x.exp == '0);
    c.inf  = (x.exp == EXP_W'(EXP_MAX)) && (x.frac == '0);
    c.nan  = (x.exp == EXP_W'(EXP_MAX)) && (x.frac != '0);
    c.sig  = {1'b1, x.frac};
    return c;
  endfunction

  // Reserved encodings 1xx behave as nearest-even.
  function automatic logic [2:0] decode_mode(input logic [2:0] rnd);
    logic [2:0] mode;
    mode = rnd[2] ? RND_NE : rnd;
    return mode;
  endfunction

  function automatic logic round_up(input logic [2:0] mode, input logic sign,
                                    input logic lsb, input logic guard,
                                    input logic rest);
    logic inc;
    case (mode)
      RND_RZ:  inc = 1'b0;
      RND_UP:  inc = (guard | rest) & ~sign;
      RND_DN:  inc = (guard | rest) & sign;
      default: inc = guard & (rest | lsb);
    endcase
    return inc;
  endfunction

  // Overflow goes to infinity only when the rounding direction points away
  // from zero for this sign; otherwise it clamps to the largest finite value.
  function automatic logic overflow_to_inf(input logic [2:0] mode, input logic sign);
    logic to_inf;
    case (mode)
      RND_RZ:  to_inf = 1'b0;
      RND_UP:  to_inf = ~sign;
      RND_DN:  to_inf = sign;
      default: to_inf = 1'b1;
    endcase
    return to_inf;
  endfunction

  function automatic fp24_t make_inf(input logic sign);
    fp24_t r;
    r.sign = sign;
    r.exp  = EXP_W'(EXP_MAX);
    r.frac = '0;
    return r;
  endfunction

  function automatic fp24_t make_zero(input logic sign);
    fp24_t r;
    r.sign = sign;
    r.exp  = '0;
    r.frac = '0;
    return r;
  endfunction

endpackage

// File: rtl/fp_addsub24_unit_lzc20.sv
// Leading-zero counter over the 20-bit extended significand; an all-zero
// input reports 20.
module lzc20
  import fp24_pkg::*;
(
  input  logic [EXT_W-1:0] value,
  output logic [LZC_W-1:0] count
);

  // Ascending scan so the most significant set bit has the final say.
  always_comb begin
    count = LZC_W'(EXT_W);
    for (int i = 0; i < EXT_W; i++) begin
      if (value[i]) count = LZC_W'(EXT_W - 1 - i);
    end
  end

endmodule

// File: rtl/fp_addsub24_unit.sv
// Registered 24-bit floating-point adder/subtractor: unpack, align, add,
// normalize, round and special-case selection feed a single output register.
module fp_addsub24_unit
  import fp24_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [23:0] inst_a,
  input  logic [23:0] inst_b,
  input  logic [2:0]  inst_rnd,
  input  logic        inst_op,
  output logic [23:0] z_inst
);

  fp24_t       a, b;
  fp24_class_t ca, cb;
  logic        sign_b;
  logic        eff_sub;
  logic [2:0]  mode;

  assign a       = fp24_t'(inst_a);
  assign b       = fp24_t'(inst_b);
  assign ca      = classify(a);
  assign cb      = classify(b);
  assign sign_b  = b.sign ^ inst_op;
  assign eff_sub = a.sign ^ sign_b;
  assign mode    = decode_mode(inst_rnd);

  // Order by magnitude so the subtraction below never goes negative.
  logic             a_ge_b;
  logic [EXP_W-1:0] big_exp, small_exp, exp_diff;
  logic [SIG_W-1:0] big_sig, small_sig;
  logic             big_sign;

  assign a_ge_b    = {a.exp, a.frac} >= {b.exp, b.frac};
  assign big_exp   = a_ge_b ? a.exp  : b.exp;
  assign small_exp = a_ge_b ? b.exp  : a.exp;
  assign big_sig   = a_ge_b ? ca.sig : cb.sig;
  assign small_sig = a_ge_b ? cb.sig : ca.sig;
  assign big_sign  = a_ge_b ? a.sign : sign_b;
  assign exp_diff  = big_exp - small_exp;

  logic [LZC_W-1:0] shift_amt;
  logic [EXT_W-1:0] small_ext, small_shifted, lost_mask, small_aligned, big_ext;
  logic             lost;
  logic [EXT_W:0]   sum;

  // A shift of 19 already parks the hidden bit in the sticky position, so
  // larger distances cannot change the result.
  assign shift_amt     = (exp_diff > 7'd19) ? 5'd19 : exp_diff[LZC_W-1:0];
  assign small_ext     = {small_sig, 3'b000};
  assign big_ext       = {big_sig, 3'b000};
  assign small_shifted = small_ext >> shift_amt;
  assign lost_mask     = (EXT_W'(1) << shift_amt) - EXT_W'(1);
  assign lost          = |(small_ext & lost_mask);
  assign small_aligned = {small_shifted[EXT_W-1:1], small_shifted[0] | lost};

  assign sum = eff_sub ? ({1'b0, big_ext} - {1'b0, small_aligned})
                       : ({1'b0, big_ext} + {1'b0, small_aligned});

  logic [LZC_W-1:0] lz;

  lzc20 u_lzc (
    .value (sum[EXT_W-1:0]),
    .count (lz)
  );

  logic [EXT_W-1:0]  norm_sig;
  logic signed [8:0] norm_exp;
  logic              inc;
  logic [SIG_W:0]    rounded;
  logic signed [8:0] round_exp;
  logic [FRAC_W-1:0] round_frac;

  // NOTE: every combinational output is given a default before any branch so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    norm_sig = '0;
    norm_exp = '0;
    if (sum[EXT_W]) begin
      norm_sig = {sum[EXT_W:2], sum[1] | sum[0]};
      norm_exp = $signed({2'b00, big_exp}) + 9'sd1;
    end else begin
      norm_sig = sum[EXT_W-1:0] << lz;
      norm_exp = $signed({2'b00, big_exp}) - $signed({4'b0000, lz});
    end

    inc        = round_up(mode, big_sign, norm_sig[3], norm_sig[2],
                          norm_sig[1] | norm_sig[0]);
    rounded    = {1'b0, norm_sig[EXT_W-1:3]} + {{SIG_W{1'b0}}, inc};
    round_exp  = norm_exp + $signed({8'b0, rounded[SIG_W]});
    round_frac = rounded[SIG_W] ? '0 : rounded[FRAC_W-1:0];
  end

  fp24_t result;
  logic  zero_sign;

  // Exact-zero and underflow results are +0 except when rounding toward -inf.
  assign zero_sign = (mode == RND_DN);

  always_comb begin
    result = make_zero(1'b0);
    if (ca.nan || cb.nan) begin
      result = fp24_t'(QNAN);
    end else if (ca.inf && cb.inf && eff_sub) begin
      result = fp24_t'(QNAN);
    end else if (ca.inf) begin
      result = make_inf(a.sign);
    end else if (cb.inf) begin
      result = make_inf(sign_b);
    end else if (ca.zero && cb.zero) begin
      result = make_zero(eff_sub ? zero_sign : a.sign);
    end else if (ca.zero) begin
      result = {sign_b, b.exp, b.frac};
    end else if (cb.zero) begin
      result = a;
    end else if (sum == '0) begin
      result = make_zero(zero_sign);
    end else if (norm_exp <= 9'sd0) begin
      result = make_zero(zero_sign);
    end else if (round_exp >= 9'sd127) begin
      result = overflow_to_inf(mode, big_sign) ? make_inf(big_sign)
                                               : {big_sign, MAX_FIN[22:0]};
    end else begin
      result = {big_sign, round_exp[EXP_W-1:0], round_frac};
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) z_inst <= '0;
    else        z_inst <= result;
  end

endmodule

// File: tb/tb_fp_addsub24_unit.sv
// Self-checking bench for fp_addsub24_unit: directed vectors from the format
// rules plus random back-to-back traffic scored against an exact-integer model.
module tb_fp_addsub24_unit;

  logic        clock;
  logic        reset;
  logic [23:0] inst_a;
  logic [23:0] inst_b;
  logic [2:0]  inst_rnd;
  logic        inst_op;
  logic [23:0] z_inst;

  int errors = 0;
  int checks = 0;

  logic [23:0] sb_q[$];

  typedef struct packed {
    logic [23:0] a;
    logic [23:0] b;
    logic        op;
    logic [2:0]  rnd;
    logic [23:0] want;
  } vec_t;

  fp_addsub24_unit dut (
    .clock    (clock),
    .reset    (reset),
    .inst_a   (inst_a),
    .inst_b   (inst_b),
    .inst_rnd (inst_rnd),
    .inst_op  (inst_op),
    .z_inst   (z_inst)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: exact sum as a wide integer scaled to the smaller exponent,
  // then a single rounding step on the exact remainder.
  function automatic logic [23:0] ref_model(input logic [23:0] a, input logic [23:0] b,
                                            input logic op, input logic [2:0] rnd);
    logic [2:0]   m;
    logic         sa, sb, sr, dn, inc;
    int           ea, eb, emin, p, e;
    bit           za, zb, ia, ib, na, nb;
    logic [159:0] ma, mb, mag, keep, rem, half;
    m  = rnd[2] ? 3'd0 : rnd;
    dn = (m == 3'd3);
    sa = a[23];
    sb = b[23] ^ op;
    ea = int'(a[22:16]);
    eb = int'(b[22:16]);
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == 127) && (a[15:0] == 16'h0);
    ib = (eb == 127) && (b[15:0] == 16'h0);
    na = (ea == 127) && (a[15:0] != 16'h0);
    nb = (eb == 127) && (b[15:0] != 16'h0);
    if (na || nb) return 24'h7F8000;
    if (ia && ib && (sa != sb)) return 24'h7F8000;
    if (ia) return {sa, 7'h7F, 16'h0};
    if (ib) return {sb, 7'h7F, 16'h0};
    if (za && zb) return {((sa == sb) ? sa : dn), 23'h0};
    if (za) return {sb, b[22:0]};
    if (zb) return a;
    emin = (ea < eb) ? ea : eb;
    ma = 160'({1'b1, a[15:0]}) << (ea - emin);
    mb = 160'({1'b1, b[15:0]}) << (eb - emin);
    if (sa == sb) begin
      mag = ma + mb; sr = sa;
    end else if (ma >= mb) begin
      mag = ma - mb; sr = sa;
    end else begin
      mag = mb - ma; sr = sb;
    end
    if (mag == 0) return {dn, 23'h0};
    p = 0;
    for (int i = 0; i < 160; i++) if (mag[i]) p = i;
    e = emin + p - 16;
    if (e <= 0) return {dn, 23'h0};
    if (p > 16) begin
      keep = mag >> (p - 16);
      rem  = mag & ((160'd1 << (p - 16)) - 160'd1);
      half = 160'd1 << (p - 17);
    end else begin
      keep = mag << (16 - p);
      rem  = 0;
      half = 1;
    end
    case (m)
      3'd1:    inc = 1'b0;
      3'd2:    inc = (rem != 0) && !sr;
      3'd3:    inc = (rem != 0) && sr;
      default: inc = (rem > half) || ((rem == half) && keep[0]);
    endcase
    keep = keep + 160'(inc);
    if (keep[17]) begin
      keep = keep >> 1;
      e    = e + 1;
    end
    if (e >= 127) begin
      if ((m == 3'd0) || ((m == 3'd2) && !sr) || ((m == 3'd3) && sr))
        return {sr, 7'h7F, 16'h0};
      return {sr, 23'h7EFFFF};
    end
    return {sr, 7'(e), keep[15:0]};
  endfunction

  function automatic logic [23:0] rand_operand(input int near_exp);
    int          kind, e;
    logic        s;
    logic [15:0] f;
    kind = int'($urandom_range(0, 19));
    s    = 1'($urandom_range(0, 1));
    f    = 16'($urandom);
    e    = int'($urandom_range(1, 126));
    case (kind)
      0:       return {s, 7'h00, 16'h0};
      1:       return {s, 7'h7F, 16'h0};
      2:       return {s, 7'h7F, f | 16'h1};
      3:       return {s, 7'h00, f | 16'h1};
      4, 5, 6, 7, 8, 9, 10, 11: begin
        e = near_exp + int'($urandom_range(0, 6)) - 3;
        if (e < 1) e = 1;
        if (e > 126) e = 126;
      end
      default: ;
    endcase
    return {s, 7'(e), f};
  endfunction

  task automatic issue(input logic [23:0] a, input logic [23:0] b, input logic op,
                       input logic [2:0] rnd, input logic [23:0] want);
    inst_a   = a;
    inst_b   = b;
    inst_op  = op;
    inst_rnd = rnd;
    sb_q.push_back(want);
  endtask

  task automatic test_reset();
    logic [23:0] want;
    reset = 1'b0;
    inst_a = 24'h3F0000; inst_b = 24'h3F0000; inst_op = 1'b0; inst_rnd = 3'd0;
    #1;
    checks++;
    if (z_inst !== 24'h000000) begin
      errors++; $display("FAIL reset_async: z_inst=%h want 000000", z_inst);
    end
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (z_inst !== 24'h000000) begin
      errors++; $display("FAIL reset_held: z_inst=%h want 000000", z_inst);
    end
    @(negedge clock);
    reset = 1'b1;
    issue(24'h3F0000, 24'h3F0000, 1'b0, 3'd0, 24'h400000);
    @(posedge clock); #1;
    want = sb_q.pop_front(); checks++;
    if (z_inst !== want) begin
      errors++; $display("FAIL reset_first: z_inst=%h want %h", z_inst, want);
    end
  endtask

  task automatic test_exact();
    vec_t v[6];
    logic [23:0] want;
    v[0] = '{24'h400000, 24'h3F0000, 1'b0, 3'd0, 24'h408000};
    v[1] = '{24'h400000, 24'h3F0000, 1'b1, 3'd0, 24'h3F0000};
    v[2] = '{24'h3F0000, 24'h3F0000, 1'b1, 3'd0, 24'h000000};
    v[3] = '{24'h3F0000, 24'h3F0000, 1'b1, 3'd3, 24'h800000};
    v[4] = '{24'h800000, 24'h800000, 1'b0, 3'd0, 24'h800000};
    v[5] = '{24'h000123, 24'h3F0000, 1'b1, 3'd0, 24'hBF0000};
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      issue(v[i].a, v[i].b, v[i].op, v[i].rnd, v[i].want);
      @(posedge clock); #1;
      want = sb_q.pop_front(); checks++;
      if (z_inst !== want) begin
        errors++; $display("FAIL exact[%0d]: z_inst=%h want %h", i, z_inst, want);
      end
    end
  endtask

  task automatic test_rounding();
    vec_t v[5];
    logic [23:0] want;
    v[0] = '{24'h3F0000, 24'h2E0000, 1'b0, 3'd0, 24'h3F0000};
    v[1] = '{24'h3F0000, 24'h2E0000, 1'b0, 3'd2, 24'h3F0001};
    v[2] = '{24'h3F0000, 24'h2E0000, 1'b0, 3'd1, 24'h3F0000};
    v[3] = '{24'h3F0001, 24'h2E0000, 1'b0, 3'd0, 24'h3F0002};
    v[4] = '{24'h3F0001, 24'h2E0000, 1'b0, 3'd6, 24'h3F0002};
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      issue(v[i].a, v[i].b, v[i].op, v[i].rnd, v[i].want);
      @(posedge clock); #1;
      want = sb_q.pop_front(); checks++;
      if (z_inst !== want) begin
        errors++; $display("FAIL rounding[%0d]: z_inst=%h want %h", i, z_inst, want);
      end
    end
  endtask

  task automatic test_specials();
    vec_t v[4];
    logic [23:0] want;
    v[0] = '{24'h7F0000, 24'h7F0000, 1'b1, 3'd0, 24'h7F8000};
    v[1] = '{24'h7F0000, 24'h3F0000, 1'b0, 3'd0, 24'h7F0000};
    v[2] = '{24'h7F8001, 24'h3F0000, 1'b0, 3'd0, 24'h7F8000};
    v[3] = '{24'h3F0000, 24'h7F0000, 1'b1, 3'd0, 24'hFF0000};
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      issue(v[i].a, v[i].b, v[i].op, v[i].rnd, v[i].want);
      @(posedge clock); #1;
      want = sb_q.pop_front(); checks++;
      if (z_inst !== want) begin
        errors++; $display("FAIL specials[%0d]: z_inst=%h want %h", i, z_inst, want);
      end
    end
  endtask

  task automatic test_overflow();
    vec_t v[4];
    logic [23:0] want;
    v[0] = '{24'h7EFFFF, 24'h7EFFFF, 1'b0, 3'd0, 24'h7F0000};
    v[1] = '{24'h7EFFFF, 24'h7EFFFF, 1'b0, 3'd1, 24'h7EFFFF};
    v[2] = '{24'hFEFFFF, 24'hFEFFFF, 1'b0, 3'd2, 24'hFEFFFF};
    v[3] = '{24'hFEFFFF, 24'hFEFFFF, 1'b0, 3'd3, 24'hFF0000};
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      issue(v[i].a, v[i].b, v[i].op, v[i].rnd, v[i].want);
      @(posedge clock); #1;
      want = sb_q.pop_front(); checks++;
      if (z_inst !== want) begin
        errors++; $display("FAIL overflow[%0d]: z_inst=%h want %h", i, z_inst, want);
      end
    end
  endtask

  task automatic test_cancellation();
    vec_t v[3];
    logic [23:0] want;
    v[0] = '{24'h3F0001, 24'h3F0000, 1'b1, 3'd0, 24'h2F0000};
    v[1] = '{24'h010001, 24'h010000, 1'b1, 3'd0, 24'h000000};
    v[2] = '{24'h010001, 24'h010000, 1'b1, 3'd3, 24'h800000};
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      issue(v[i].a, v[i].b, v[i].op, v[i].rnd, v[i].want);
      @(posedge clock); #1;
      want = sb_q.pop_front(); checks++;
      if (z_inst !== want) begin
        errors++; $display("FAIL cancel[%0d]: z_inst=%h want %h", i, z_inst, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] a, b, want;
    logic        op;
    logic [2:0]  rnd;
    int          near;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      near = int'($urandom_range(1, 126));
      a    = rand_operand(near);
      b    = rand_operand(near);
      op   = 1'($urandom_range(0, 1));
      rnd  = 3'($urandom_range(0, 7));
      if ((i % 8) == 0) b = {a[23:16], a[15:0] ^ 16'($urandom_range(0, 7))};
      issue(a, b, op, rnd, ref_model(a, b, op, rnd));
      @(posedge clock); #1;
      want = sb_q.pop_front(); checks++;
      if (z_inst !== want) begin
        errors++;
        $display("FAIL b2b[%0d] a=%h b=%h op=%0d rnd=%0d: z_inst=%h want %h",
                 i, a, b, op, rnd, z_inst, want);
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [23:0] want;
    @(negedge clock);
    issue(24'h400000, 24'h3F0000, 1'b0, 3'd0, 24'h408000);
    @(posedge clock); #1;
    want = sb_q.pop_front(); checks++;
    if (z_inst !== want) begin
      errors++; $display("FAIL mid_before: z_inst=%h want %h", z_inst, want);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (z_inst !== 24'h000000) begin
      errors++; $display("FAIL mid_async: z_inst=%h want 000000", z_inst);
    end
    @(posedge clock); #1;
    checks++;
    if (z_inst !== 24'h000000) begin
      errors++; $display("FAIL mid_held: z_inst=%h want 000000", z_inst);
    end
    sb_q.delete();
    @(negedge clock);
    reset = 1'b1;
    issue(24'h400000, 24'h3F0000, 1'b1, 3'd0, 24'h3F0000);
    @(posedge clock); #1;
    want = sb_q.pop_front(); checks++;
    if (z_inst !== want) begin
      errors++; $display("FAIL mid_after: z_inst=%h want %h", z_inst, want);
    end
  endtask

  initial begin
    test_reset();
    test_exact();
    test_rounding();
    test_specials();
    test_overflow();
    test_cancellation();
    test_back_to_back();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
